// File: rtl/es_mem_req.sv
// EX-stage data-SRAM request issuer: decodes load/store, builds the request,
// flags address errors and filters responses of flushed instructions.
module es_mem_req (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] vaddr,
    input  logic [31:0] rt_value,
    input  logic        es_ex_in,
    input  logic        es_go,
    input  logic        flush,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic        ms_data_ok,
    output logic        req_ready_go,
    output logic        mem_access,
    output logic        adel,
    output logic        ades,
    output logic [1:0]  ldb,
    output logic [5:0]  ld_word
);

    typedef enum logic [1:0] {IDLE, REQ, ABORT, DONE} state_t;

    state_t      state;
    logic [1:0]  outstanding;
    logic [1:0]  discard;

    logic op_lb, op_lbu, op_lh, op_lhu, op_lw, op_lwl, op_lwr;
    logic op_sb, op_sh, op_sw, op_swl, op_swr;
    logic is_load, is_store, align_err, start;
    logic [1:0] off;

    assign off    = vaddr[1:0];
    assign op_lb  = mem_op == 4'b0001;
    assign op_lbu = mem_op == 4'b0010;
    assign op_lh  = mem_op == 4'b0011;
    assign op_lhu = mem_op == 4'b0100;
    assign op_lw  = mem_op == 4'b0101;
    assign op_lwl = mem_op == 4'b0110;
    assign op_lwr = mem_op == 4'b0111;
    assign op_sb  = mem_op == 4'b1001;
    assign op_sh  = mem_op == 4'b1010;
    assign op_sw  = mem_op == 4'b1011;
    assign op_swl = mem_op == 4'b1100;
    assign op_swr = mem_op == 4'b1101;

    assign is_load  = op_lb | op_lbu | op_lh | op_lhu | op_lw | op_lwl | op_lwr;
    assign is_store = op_sb | op_sh | op_sw | op_swl | op_swr;

    assign align_err = ((op_lh | op_lhu | op_sh) & vaddr[0])
                     | ((op_lw | op_sw) & (off != 2'b00));

    assign adel = es_valid & is_load & align_err;
    assign ades = es_valid & is_store & align_err;
    assign mem_access = es_valid & (is_load | is_store) & ~es_ex_in
                      & ~adel & ~ades;
    assign ldb     = off;
    assign ld_word = {op_lb, op_lbu, op_lh, op_lhu, op_lwl, op_lwr};

    assign start = mem_access & ~flush & (state == IDLE)
                 & (outstanding < 2'd2);

    logic [1:0]  nx_size;
    logic [31:0] nx_addr;
    logic [3:0]  nx_wstrb;
    logic [31:0] nx_wdata;

    always_comb begin
        nx_size  = 2'd2;
        nx_addr  = vaddr;
        nx_wstrb = 4'b0000;
        nx_wdata = 32'h0;
        if (op_lb | op_lbu | op_sb) nx_size = 2'd0;
        if (op_lh | op_lhu | op_sh) nx_size = 2'd1;
        // Unaligned-word ops always access the whole containing word.
        if (op_lwl | op_lwr | op_swl | op_swr)
            nx_addr = {vaddr[31:2], 2'b00};
        unique case (1'b1)
            op_sb: begin
                nx_wstrb = 4'b0001 << off;
                nx_wdata = {4{rt_value[7:0]}};
            end
            op_sh: begin
                nx_wstrb = off[1] ? 4'b1100 : 4'b0011;
                nx_wdata = {2{rt_value[15:0]}};
            end
            op_sw: begin
                nx_wstrb = 4'b1111;
                nx_wdata = rt_value;
            end
            op_swl: begin
                nx_wstrb = 4'b1111 >> (2'd3 - off);
                nx_wdata = rt_value >> {(2'd3 - off), 3'b000};
            end
            op_swr: begin
                nx_wstrb = 4'b1111 << off;
                nx_wdata = rt_value << {off, 3'b000};
            end
            default: ;
        endcase
    end

    logic       inc, dec, abort_inc, disc_dec;
    logic [1:0] out_nxt, disc_raw, disc_nxt;

    assign inc       = data_sram_req & data_sram_addr_ok;
    assign dec       = data_sram_data_ok & (outstanding != 2'd0);
    assign abort_inc = (state == ABORT) & data_sram_addr_ok;
    assign disc_dec  = data_sram_data_ok & (discard != 2'd0);
    assign out_nxt   = outstanding + {1'b0, inc} - {1'b0, dec};

    // On flush everything in flight (including a same-cycle acceptance)
    // becomes discarded; a still-pending ABORT request adds itself later.
    always_comb begin
        if (flush) disc_raw = out_nxt;
        else       disc_raw = discard + {1'b0, abort_inc} - {1'b0, disc_dec};
        disc_nxt = (disc_raw > out_nxt) ? out_nxt : disc_raw;
    end

    assign ms_data_ok = data_sram_data_ok & (discard == 2'd0) & ~flush;

    assign req_ready_go = ~mem_access
                        | ((state == REQ) & data_sram_addr_ok)
                        | (state == DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= 2'd0;
            discard     <= 2'd0;
        end else begin
            outstanding <= out_nxt;
            discard     <= disc_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            data_sram_req   <= 1'b0;
            data_sram_wr    <= 1'b0;
            data_sram_size  <= 2'd0;
            data_sram_addr  <= 32'h0;
            data_sram_wstrb <= 4'b0000;
            data_sram_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= REQ;
                        data_sram_req   <= 1'b1;
                        data_sram_wr    <= is_store;
                        data_sram_size  <= nx_size;
                        data_sram_addr  <= nx_addr;
                        data_sram_wstrb <= nx_wstrb;
                        data_sram_wdata <= nx_wdata;
                    end
                end
                REQ: begin
                    if (data_sram_addr_ok) begin
                        data_sram_req <= 1'b0;
                        state <= (flush | es_go) ? IDLE : DONE;
                    end else if (flush) begin
                        state <= ABORT;
                    end
                end
                ABORT: begin
                    if (data_sram_addr_ok) begin
                        data_sram_req <= 1'b0;
                        state         <= IDLE;
                    end
                end
                DONE: begin
                    if (es_go | flush) state <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    data_sram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_es_mem_req.sv
// Directed bench for es_mem_req: request fields and responses are checked
// against scoreboard queues filled when stimulus is driven.
module tb_es_mem_req;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_valid;
    logic [3:0]  mem_op;
    logic [31:0] vaddr;
    logic [31:0] rt_value;
    logic        es_ex_in;
    logic        es_go;
    logic        flush;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic        ms_data_ok;
    logic        req_ready_go;
    logic        mem_access;
    logic        adel;
    logic        ades;
    logic [1:0]  ldb;
    logic [5:0]  ld_word;

    es_mem_req dut (
        .clk(clk), .resetn(resetn), .es_valid(es_valid),
        .mem_op(mem_op), .vaddr(vaddr), .rt_value(rt_value),
        .es_ex_in(es_ex_in), .es_go(es_go), .flush(flush),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .ms_data_ok(ms_data_ok), .req_ready_go(req_ready_go),
        .mem_access(mem_access), .adel(adel), .ades(ades),
        .ldb(ldb), .ld_word(ld_word)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    req_t req_q[$];
    logic resp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        es_valid = 1'b0; mem_op = 4'h0; es_ex_in = 1'b0;
        es_go = 1'b0; flush = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] va,
                         input logic [31:0] rt);
        es_valid = 1'b1; mem_op = op; vaddr = va; rt_value = rt;
    endtask

    task automatic push_req(input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [3:0] st,
                            input logic [31:0] wd);
        req_t r;
        r.wr = wr; r.size = sz; r.addr = a; r.wstrb = st; r.wdata = wd;
        req_q.push_back(r);
    endtask

    task automatic check_req(input string tag);
        req_t r;
        if (req_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            r = req_q.pop_front();
            chk({tag, "_wr"}, {31'd0, data_sram_wr}, {31'd0, r.wr});
            chk({tag, "_size"}, {30'd0, data_sram_size}, {30'd0, r.size});
            chk({tag, "_addr"}, data_sram_addr, r.addr);
            chk({tag, "_wstrb"}, {28'd0, data_sram_wstrb}, {28'd0, r.wstrb});
            if (r.wr) chk({tag, "_wdata"}, data_sram_wdata, r.wdata);
        end
    endtask

    task automatic check_resp(input string tag);
        logic e;
        if (resp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = resp_q.pop_front();
            chk(tag, {31'd0, ms_data_ok}, {31'd0, e});
        end
    endtask

    // One full transaction: addr_ok in the first REQ cycle, data_ok next.
    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [31:0] va, input logic [31:0] rt,
                         input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [3:0] st,
                         input logic [31:0] wd);
        drive(op, va, rt);
        push_req(wr, sz, a, st, wd);
        #1;
        chk({tag, "_stall"}, {31'd0, req_ready_go}, 32'd0);
        chk({tag, "_noreq"}, {31'd0, data_sram_req}, 32'd0);
        tick;
        data_sram_addr_ok = 1'b1; es_go = 1'b1;
        #1;
        chk({tag, "_req"}, {31'd0, data_sram_req}, 32'd1);
        check_req(tag);
        chk({tag, "_go"}, {31'd0, req_ready_go}, 32'd1);
        tick;
        quiet;
        data_sram_data_ok = 1'b1;
        resp_q.push_back(1'b1);
        #1;
        chk({tag, "_reqdrop"}, {31'd0, data_sram_req}, 32'd0);
        check_resp({tag, "_resp"});
        tick;
        data_sram_data_ok = 1'b0;
        #1;
        chk({tag, "_resp_end"}, {31'd0, ms_data_ok}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        quiet;
        vaddr = 32'h0; rt_value = 32'h0;
        resetn = 1'b0;
        #12;
        chk("rst_req", {31'd0, data_sram_req}, 32'd0);
        chk("rst_rrg", {31'd0, req_ready_go}, 32'd1);
        chk("rst_addr", data_sram_addr, 32'h0);
        chk("rst_wstrb", {28'd0, data_sram_wstrb}, 32'h0);
        chk("rst_ms", {31'd0, ms_data_ok}, 32'd0);
        tick;
        resetn = 1'b1;
        tick;

        // LW with addr_ok in the second request cycle
        drive(4'b0101, 32'h1000_0004, 32'hCAFE_F00D);
        push_req(1'b0, 2'd2, 32'h1000_0004, 4'b0000, 32'h0);
        #1;
        chk("lw_access", {31'd0, mem_access}, 32'd1);
        chk("lw_stall", {31'd0, req_ready_go}, 32'd0);
        tick;
        chk("lw_req1", {31'd0, data_sram_req}, 32'd1);
        chk("lw_stall1", {31'd0, req_ready_go}, 32'd0);
        tick;
        data_sram_addr_ok = 1'b1; es_go = 1'b1;
        #1;
        chk("lw_req2", {31'd0, data_sram_req}, 32'd1);
        check_req("lw");
        chk("lw_go", {31'd0, req_ready_go}, 32'd1);
        tick;
        quiet;
        #1;
        chk("lw_reqdrop", {31'd0, data_sram_req}, 32'd0);
        tick;
        data_sram_data_ok = 1'b1;
        resp_q.push_back(1'b1);
        #1;
        check_resp("lw_resp");
        tick;
        data_sram_data_ok = 1'b0;
        #1;
        chk("lw_resp_once", {31'd0, ms_data_ok}, 32'd0);

        // store and unaligned-word variants
        do_op("sb", 4'b1001, 32'h2000_0002, 32'h1234_56AB,
              1'b1, 2'd0, 32'h2000_0002, 4'b0100, 32'hABAB_ABAB);
        do_op("swr", 4'b1101, 32'h3000_0001, 32'h1122_3344,
              1'b1, 2'd2, 32'h3000_0000, 4'b1110, 32'h2233_4400);
        do_op("swl", 4'b1100, 32'h3000_0005, 32'h1122_3344,
              1'b1, 2'd2, 32'h3000_0004, 4'b0011, 32'h0000_1122);
        do_op("sh", 4'b1010, 32'h3000_000A, 32'hAAAA_5555,
              1'b1, 2'd1, 32'h3000_000A, 4'b1100, 32'h5555_5555);
        do_op("lwl", 4'b0110, 32'h4000_0003, 32'h0,
              1'b0, 2'd2, 32'h4000_0000, 4'b0000, 32'h0);

        // address errors and suppressed accesses
        drive(4'b0011, 32'h1234_5673, 32'h0);
        #1;
        chk("lh_adel", {31'd0, adel}, 32'd1);
        chk("lh_ades", {31'd0, ades}, 32'd0);
        chk("lh_access", {31'd0, mem_access}, 32'd0);
        chk("lh_rrg", {31'd0, req_ready_go}, 32'd1);
        chk("lh_ldb", {30'd0, ldb}, 32'd3);
        chk("lh_ldword", {26'd0, ld_word}, 32'b001000);
        tick;
        chk("lh_noreq", {31'd0, data_sram_req}, 32'd0);
        drive(4'b1011, 32'h1234_5672, 32'h0);
        #1;
        chk("sw_ades", {31'd0, ades}, 32'd1);
        chk("sw_adel", {31'd0, adel}, 32'd0);
        chk("sw_access", {31'd0, mem_access}, 32'd0);
        tick;
        chk("sw_noreq", {31'd0, data_sram_req}, 32'd0);
        drive(4'b0101, 32'h1234_5670, 32'h0);
        es_ex_in = 1'b1;
        #1;
        chk("ex_access", {31'd0, mem_access}, 32'd0);
        chk("ex_adel", {31'd0, adel}, 32'd0);
        tick;
        chk("ex_noreq", {31'd0, data_sram_req}, 32'd0);
        quiet;
        mem_op = 4'b0111;
        #1;
        chk("lwr_ldword", {26'd0, ld_word}, 32'b000001);
        chk("inv_access", {31'd0, mem_access}, 32'd0);
        mem_op = 4'h0;

        // flush in REQ, addr_ok two cycles later: response is discarded
        drive(4'b0101, 32'h5000_0000, 32'h0);
        push_req(1'b0, 2'd2, 32'h5000_0000, 4'b0000, 32'h0);
        tick;
        flush = 1'b1;
        #1;
        chk("ab_req0", {31'd0, data_sram_req}, 32'd1);
        check_req("ab");
        tick;
        quiet;
        #1;
        chk("ab_req1", {31'd0, data_sram_req}, 32'd1);
        chk("ab_addr", data_sram_addr, 32'h5000_0000);
        tick;
        data_sram_addr_ok = 1'b1;
        #1;
        chk("ab_req2", {31'd0, data_sram_req}, 32'd1);
        tick;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        resp_q.push_back(1'b0);
        #1;
        chk("ab_reqdrop", {31'd0, data_sram_req}, 32'd0);
        check_resp("ab_resp");
        tick;
        data_sram_data_ok = 1'b0;
        do_op("lb_after", 4'b0001, 32'h7000_0003, 32'h0,
              1'b0, 2'd0, 32'h7000_0003, 4'b0000, 32'h0);

        // flush together with start: nothing issued
        drive(4'b0101, 32'h8000_0000, 32'h0);
        flush = 1'b1;
        #1;
        chk("fs_rrg", {31'd0, req_ready_go}, 32'd0);
        tick;
        quiet;
        #1;
        chk("fs_noreq", {31'd0, data_sram_req}, 32'd0);
        tick;
        chk("fs_noreq2", {31'd0, data_sram_req}, 32'd0);

        // two outstanding loads hold off a third
        drive(4'b0101, 32'h6000_0000, 32'h0);
        push_req(1'b0, 2'd2, 32'h6000_0000, 4'b0000, 32'h0);
        tick;
        data_sram_addr_ok = 1'b1; es_go = 1'b1;
        #1;
        check_req("oa");
        tick;
        drive(4'b0101, 32'h6000_0004, 32'h0);
        push_req(1'b0, 2'd2, 32'h6000_0004, 4'b0000, 32'h0);
        data_sram_addr_ok = 1'b0; es_go = 1'b0;
        #1;
        chk("ob_noreq", {31'd0, data_sram_req}, 32'd0);
        tick;
        data_sram_addr_ok = 1'b1; es_go = 1'b1;
        #1;
        chk("ob_req", {31'd0, data_sram_req}, 32'd1);
        check_req("ob");
        tick;
        drive(4'b0101, 32'h6000_0008, 32'h0);
        push_req(1'b0, 2'd2, 32'h6000_0008, 4'b0000, 32'h0);
        data_sram_addr_ok = 1'b0; es_go = 1'b0;
        #1;
        chk("oc_access", {31'd0, mem_access}, 32'd1);
        chk("oc_rrg", {31'd0, req_ready_go}, 32'd0);
        tick;
        chk("oc_hold1", {31'd0, data_sram_req}, 32'd0);
        tick;
        chk("oc_hold2", {31'd0, data_sram_req}, 32'd0);
        data_sram_data_ok = 1'b1;
        resp_q.push_back(1'b1);
        #1;
        check_resp("oa_resp");
        tick;
        data_sram_data_ok = 1'b0;
        #1;
        chk("oc_hold3", {31'd0, data_sram_req}, 32'd0);
        tick;
        chk("oc_req", {31'd0, data_sram_req}, 32'd1);
        check_req("oc");
        data_sram_addr_ok = 1'b1; es_go = 1'b1;
        tick;
        quiet;
        data_sram_data_ok = 1'b1;
        resp_q.push_back(1'b1);
        #1;
        check_resp("ob_resp");
        tick;
        resp_q.push_back(1'b1);
        #1;
        check_resp("oc_resp");
        tick;
        data_sram_data_ok = 1'b0;

        // asynchronous reset in the middle of a request
        drive(4'b0101, 32'h9000_0004, 32'h0);
        tick;
        chk("rr_req", {31'd0, data_sram_req}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("rr_reqdrop", {31'd0, data_sram_req}, 32'd0);
        chk("rr_addr", data_sram_addr, 32'h0);
        chk("rr_rrg", {31'd0, req_ready_go}, 32'd0);
        tick;
        quiet;
        resetn = 1'b1;
        #1;
        chk("rr_idle", {31'd0, data_sram_req}, 32'd0);
        tick;
        do_op("sw_post", 4'b1011, 32'hA000_0000, 32'hDEAD_BEEF,
              1'b1, 2'd2, 32'hA000_0000, 4'b1111, 32'hDEAD_BEEF);

        chk("sb_req_left", req_q.size(), 32'd0);
        chk("sb_resp_left", resp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
